// File: rtl/decoder_4_16_demux_if.sv
// Bundles the select and data signals of the decode block.
//   a, b, c, d : decoder select, a is the MSB; index n = {a,b,c,d}
//   o[16:1]    : one-hot decoder outputs; o[k] corresponds to output Ok
//   in_a, in_b : demux select, in_a is the MSB; index s = {in_a,in_b}
//   z          : demux data input
//   out[4:1]   : demux outputs; out[k] corresponds to output Outk
// The master modport drives the inputs and observes the outputs.
// The slave modport is used by the decoder block itself.
interface decoder_4_16_demux_if;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic [16:1] o;
  logic        in_a;
  logic        in_b;
  logic        z;
  logic [4:1]  out;

  modport master (
    output a, b, c, d, in_a, in_b, z,
    input  o, out
  );

  modport slave (
    input  a, b, c, d, in_a, in_b, z,
    output o, out
  );
endinterface

// File: rtl/decoder_4_16_demux.sv
// Registered 4-to-16 one-hot decoder and 1-to-4 demultiplexer.
// The two functions share only the clock and reset.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; forces every output to 0
//   bus : decoder_4_16_demux_if.slave (selects and data in, decoded outputs out)
// OUT_REG = 1 registers all outputs, giving 1 cycle of latency.
// OUT_REG = 0 makes all outputs combinational; clk and rst are then unused.
module decoder_4_16_demux #(
  parameter int unsigned OUT_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  decoder_4_16_demux_if.slave    bus
);

  logic [3:0]  dec_idx;
  logic [1:0]  dmx_idx;
  logic [16:1] o_d;
  logic [4:1]  out_d;

  assign dec_idx = {bus.a, bus.b, bus.c, bus.d};
  assign dmx_idx = {bus.in_a, bus.in_b};

  always_comb begin
    o_d = 16'(1) << dec_idx;
    out_d = 4'b0;
    if (bus.z) begin
      out_d = 4'(1) << dmx_idx;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    // All-zero during reset is the only non-one-hot state the decoder may show.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bus.o   <= '0;
        bus.out <= '0;
      end else begin
        bus.o   <= o_d;
        bus.out <= out_d;
      end
    end
  end else begin : g_comb
    always_comb begin
      bus.o   = o_d;
      bus.out = out_d;
    end
  end

endmodule

// File: tb/tb_decoder_4_16_demux.sv
// Self-checking bench for decoder_4_16_demux.
// A registered build (OUT_REG=1) is checked through a scoreboard queue: the
// expected outputs are pushed when inputs are driven and popped one cycle later.
// A combinational build (OUT_REG=0) is checked right after each drive.
module tb_decoder_4_16_demux;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decoder_4_16_demux_if bus_reg ();
  decoder_4_16_demux_if bus_comb ();

  decoder_4_16_demux #(.OUT_REG(1)) u_dut_reg (
    .clk (clk),
    .rst (rst),
    .bus (bus_reg.slave)
  );

  decoder_4_16_demux #(.OUT_REG(0)) u_dut_comb (
    .clk (clk),
    .rst (rst),
    .bus (bus_comb.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Each entry is {out[4:1], o[16:1]}.
  logic [19:0] exp_q[$];

  task automatic check_val(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference truth tables, independent of the RTL.
  function automatic logic [19:0] model(input logic [3:0] n, input logic [1:0] s,
                                        input logic zz);
    logic [15:0] o_exp;
    logic [3:0]  out_exp;
    o_exp = '0;
    out_exp = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == int'(n)) o_exp[k] = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      if (zz && k == int'(s)) out_exp[k] = 1'b1;
    end
    return {out_exp, o_exp};
  endfunction

  task automatic drive(input logic [3:0] n, input logic [1:0] s, input logic zz);
    {bus_reg.a, bus_reg.b, bus_reg.c, bus_reg.d}    = n;
    {bus_reg.in_a, bus_reg.in_b}                    = s;
    bus_reg.z                                       = zz;
    {bus_comb.a, bus_comb.b, bus_comb.c, bus_comb.d} = n;
    {bus_comb.in_a, bus_comb.in_b}                   = s;
    bus_comb.z                                       = zz;
  endtask

  // Compare the pending registered result, then apply new inputs.
  task automatic step(input logic [3:0] n, input logic [1:0] s, input logic zz);
    logic [19:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("reg_out", {bus_reg.out, bus_reg.o}, e);
      check_val("reg_onehot", 20'($countones(bus_reg.o)), 20'd1);
    end
    drive(n, s, zz);
    exp_q.push_back(model(n, s, zz));
    #1;
    check_val("comb_out", {bus_comb.out, bus_comb.o}, model(n, s, zz));
  endtask

  initial begin
    rst = 1'b1;
    drive(4'd0, 2'd0, 1'b0);

    // Held in reset: registered outputs all zero, combinational ones unaffected.
    repeat (3) begin
      @(negedge clk);
      check_val("reset_zero", {bus_reg.out, bus_reg.o}, 20'd0);
      check_val("comb_in_reset", {bus_comb.out, bus_comb.o}, model(4'd0, 2'd0, 1'b0));
    end
    rst = 1'b0;
    exp_q.push_back(model(4'd0, 2'd0, 1'b0));

    // Exhaustive decoder sweep with the demux idle.
    for (int i = 0; i < 16; i++) step(4'(i), 2'd0, 1'b0);

    // Demux sweep with Z=1, then Z=0.
    for (int i = 0; i < 4; i++) step(4'd5, 2'(i), 1'b1);
    for (int i = 0; i < 4; i++) step(4'd10, 2'(i), 1'b0);

    // All decoder bits flip at once while the demux inputs toggle too.
    step(4'b0111, 2'b00, 1'b0);
    step(4'b1000, 2'b11, 1'b1);
    step(4'b0111, 2'b01, 1'b1);
    step(4'b1111, 2'b10, 1'b0);

    // Asynchronous reset between edges with O12 and Out3 high.
    step(4'd11, 2'd2, 1'b1);
    @(posedge clk);
    #1;
    check_val("pre_reset", {bus_reg.out, bus_reg.o}, exp_q.pop_front());
    #1 rst = 1'b1;
    #1;
    check_val("async_reset", {bus_reg.out, bus_reg.o}, 20'd0);
    check_val("comb_ignores_rst", {bus_comb.out, bus_comb.o}, model(4'd11, 2'd2, 1'b1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("no_retained_state", {bus_reg.out, bus_reg.o}, 20'd0);
    exp_q.push_back(model(4'd11, 2'd2, 1'b1));

    // A few pseudo-random patterns after recovery.
    for (int i = 0; i < 12; i++) begin
      step(4'($urandom_range(15)), 2'($urandom_range(3)), 1'($urandom_range(1)));
    end

    // Drain the last pending result.
    step(4'd0, 2'd0, 1'b0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      check_val("reg_drain", {bus_reg.out, bus_reg.o}, exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_4_16_demux.md
Name: decoder_4_16_demux

Overview:
- Combined registered decode block holding two independent functions that share one clock and reset.
- A 4-to-16 one-hot decoder: inputs A,B,C,D drive outputs O1..O16.
- A 1-to-4 demultiplexer: data bit Z is steered by selects InA,InB to Out1..Out4.
- Used as a select/strobe generator in control paths; all outputs are registered for glitch-free fan-out.

Parameters:
- OUT_REG, 1, 1 = outputs registered on clk (1-cycle latency); 0 = purely combinational outputs, and clk/rst are ignored.

Ports:
- clk   input   1  system clock, rising edge active
- rst   input   1  asynchronous reset, active-high
- A     input   1  decoder select bit 3 (MSB)
- B     input   1  decoder select bit 2
- C     input   1  decoder select bit 1
- D     input   1  decoder select bit 0 (LSB)
- O1..O16  output  1 each  one-hot decoder outputs, active-high
- InA   input   1  demux select bit 1 (MSB)
- InB   input   1  demux select bit 0 (LSB)
- Z     input   1  demux data input
- Out1..Out4  output  1 each  demux outputs, active-high

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Decoder index: n = {A,B,C,D}, unsigned 0..15.
- Decoder output: O(n+1) = 1 and all other O = 0. Examples: 0000 -> O1, 0001 -> O2, 1000 -> O9, 1111 -> O16.
- Exactly one O output is high at any time, except during reset.
- Demux index: s = {InA,InB}, unsigned 0..3.
- Demux output: Out(s+1) = Z and all other Out = 0.
- When Z = 0, all Out are 0 regardless of the selects.
- OUT_REG=1:
  - Outputs are captured on the rising edge of clk from the inputs present at that edge.
  - Latency is exactly 1 cycle, with a new result every cycle and no handshake.
- OUT_REG=0: outputs follow the inputs combinationally with zero latency.
- Reset (OUT_REG=1):
  - While rst=1, all O1..O16 and Out1..Out4 are 0 immediately, without waiting for a clock.
  - This includes the decoder: all-zero is the only legal non-one-hot state of O.
- After rst deasserts, the first rising edge loads the decoded value.
  - Example: with inputs 0000, O1 rises at the first edge after reset release.
- Reset asserted mid-operation forces all outputs to 0 asynchronously. Decoding resumes on the first edge after deassertion; no state is retained.
- Simultaneous input changes:
  - Any combination of A..D / InA, InB, Z may change in the same cycle.
  - The registered output reflects only the values sampled at the edge, so no intermediate codes appear at the outputs.
- X/Z on any input is not a supported operating condition; outputs are unspecified in that case.
- The two functions are fully independent: decoder inputs never affect Out*, and demux inputs never affect O*.

Test Plan:
- Reset and release: hold rst=1 with A..D=0000, InA=InB=Z=0.
  - During reset, all 20 outputs are 0.
  - One cycle after release, O1=1 and all other outputs are 0.
- Exhaustive decoder sweep: drive {A,B,C,D} 0..15, one value per cycle.
  - One cycle later, only O(n+1)=1. Check 0101 -> O6, 1010 -> O11, 1111 -> O16.
  - Check a one-hot count of exactly 1 every cycle.
- Demux sweep: Z=1 with {InA,InB}=00,01,10,11 -> Out1, Out2, Out3, Out4 high in turn, one cycle later.
  - Repeat with Z=0 -> all Out stay 0.
- Simultaneous multi-bit change: step A..D from 0111 to 1000 in one cycle.
  - O8 is high, then O9 the next cycle; no other O ever asserts.
  - Concurrently toggle InA, InB and Z; Out follows independently.
- Asynchronous reset mid-run: with O12=1 and Out3=1, assert rst between clock edges.
  - All outputs drop to 0 before the next edge.
  - After deassertion, outputs resume the decoded values of the current inputs one edge later.
- OUT_REG=0 build: toggle inputs as above.
  - Outputs match the same truth tables with zero cycle latency; clk and rst have no effect.
